// File: rtl/tcdm_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tcdm_rr_arbiter
//
// Round-robin arbiter sharing one 36-bit TCDM slave port between N_MASTERS
// requesters. One pending request is selected per cycle and forwarded
// downstream. The selection is held while the slave stalls. The fixed
// one-cycle-latency response is routed back to the master that issued it.
//
// Parameters:
//   N_MASTERS   number of requesters (2..16), ID_W = $clog2(N_MASTERS)
//
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   m_req_i / m_add_i /     per-master request, address, wen (1 = read),
//   m_wen_i / m_wdata_i /   write data and byte enables
//   m_be_i
//   m_gnt_o                 per-master grant (one-hot or zero)
//   m_r_valid_o             per-master response valid (one-hot or zero)
//   m_r_rdata_o, m_r_opc_o  shared response data / error flag
//   s_req_o .. s_be_o       downstream request
//   s_gnt_i                 downstream grant
//   s_r_valid_i / s_r_rdata_i / s_r_opc_i   downstream response
//
// Optional feature, macro TCDM_ARB_ERR_CAPTURE_EN:
//   err_clr_i    clears the captured error
//   err_valid_o  an error response has been captured
//   err_id_o     master that received the first error response
//   err_addr_o   address of the transaction that returned it
// ---------------------------------------------------------------------------
module tcdm_rr_arbiter #(
  parameter int N_MASTERS = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_MASTERS-1:0]       m_req_i,
  input  logic [N_MASTERS-1:0][31:0] m_add_i,
  input  logic [N_MASTERS-1:0]       m_wen_i,
  input  logic [N_MASTERS-1:0][35:0] m_wdata_i,
  input  logic [N_MASTERS-1:0][3:0]  m_be_i,
  output logic [N_MASTERS-1:0]       m_gnt_o,
  output logic [N_MASTERS-1:0]       m_r_valid_o,
  output logic [35:0]                m_r_rdata_o,
  output logic                       m_r_opc_o,
  output logic                       s_req_o,
  output logic [31:0]                s_add_o,
  output logic                       s_wen_o,
  output logic [35:0]                s_wdata_o,
  output logic [3:0]                 s_be_o,
  input  logic                       s_gnt_i,
  input  logic                       s_r_valid_i,
  input  logic [35:0]                s_r_rdata_i,
  input  logic                       s_r_opc_i
`ifdef TCDM_ARB_ERR_CAPTURE_EN
  ,
  input  logic                       err_clr_i,
  output logic                       err_valid_o,
  output logic [$clog2(N_MASTERS)-1:0] err_id_o,
  output logic [31:0]                err_addr_o
`endif
);

  localparam int ID_W = $clog2(N_MASTERS);

  logic [ID_W-1:0] ptr;
  logic            lock_vld;
  logic [ID_W-1:0] lock_id;
  logic            rsp_vld;
  logic [ID_W-1:0] rsp_id;

  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] search_id;
  logic            search_vld;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] ptr_nxt;
  logic            handshake;

  // Scan requesters starting at ptr; the modulo keeps the candidate index
  // inside 0..N_MASTERS-1 even when N_MASTERS is not a power of two.
  always_comb begin
    search_vld = 1'b0;
    search_id  = '0;
    cand       = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      cand = ID_W'((int'(ptr) + k) % N_MASTERS);
      if (!search_vld && m_req_i[cand]) begin
        search_vld = 1'b1;
        search_id  = cand;
      end
    end
  end

  // A stalled request keeps its master selected until the slave accepts it.
  assign winner    = lock_vld ? lock_id : search_id;
  assign s_req_o   = (|m_req_i) | lock_vld;
  assign handshake = s_req_o & s_gnt_i;

  assign s_add_o   = m_add_i[winner];
  assign s_wen_o   = m_wen_i[winner];
  assign s_wdata_o = m_wdata_i[winner];
  assign s_be_o    = m_be_i[winner];

  assign ptr_nxt = (winner == ID_W'(N_MASTERS - 1)) ? '0 : winner + ID_W'(1);

  always_comb begin
    m_gnt_o = '0;
    if (handshake) begin
      m_gnt_o[winner] = 1'b1;
    end
  end

  // rsp_id is the id registered at the previous handshake, so a response
  // arriving in a cycle that also handshakes still goes to the older master.
  always_comb begin
    m_r_valid_o = '0;
    if (rsp_vld && s_r_valid_i) begin
      m_r_valid_o[rsp_id] = 1'b1;
    end
  end

  assign m_r_rdata_o = s_r_rdata_i;
  assign m_r_opc_o   = s_r_opc_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr      <= '0;
      lock_vld <= 1'b0;
      lock_id  <= '0;
      rsp_vld  <= 1'b0;
      rsp_id   <= '0;
    end else begin
      if (handshake) begin
        ptr      <= ptr_nxt;
        lock_vld <= 1'b0;
        rsp_vld  <= 1'b1;
        rsp_id   <= winner;
      end else begin
        rsp_vld <= 1'b0;
        if (s_req_o) begin
          lock_vld <= 1'b1;
          lock_id  <= winner;
        end
      end
    end
  end

`ifdef TCDM_ARB_ERR_CAPTURE_EN
  logic [31:0] rsp_addr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_addr <= '0;
    end else if (handshake) begin
      rsp_addr <= s_add_o;
    end
  end

  // Only the first error is kept; a clear wins over a same-cycle capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_valid_o <= 1'b0;
      err_id_o    <= '0;
      err_addr_o  <= '0;
    end else if (err_clr_i) begin
      err_valid_o <= 1'b0;
    end else if (!err_valid_o && rsp_vld && s_r_valid_i && s_r_opc_i) begin
      err_valid_o <= 1'b1;
      err_id_o    <= rsp_id;
      err_addr_o  <= rsp_addr;
    end
  end
`endif

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tcdm_rr_arbiter
//
// Self-checking bench for tcdm_rr_arbiter. A 4-master instance is driven by
// scenario tasks; expected responses are queued when a grant is expected
// and popped when the slave response is driven the following cycle. A
// 3-master instance checks pointer wrap for non-power-of-two counts.
// Inputs change on the falling edge, outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_tcdm_rr_arbiter;

  typedef struct {
    int          id;
    logic [35:0] data;
    logic        opc;
  } rsp_t;

  logic              clk_i = 1'b0;
  logic              rst_i;

  logic [3:0]        m_req_i;
  logic [3:0][31:0]  m_add_i;
  logic [3:0]        m_wen_i;
  logic [3:0][35:0]  m_wdata_i;
  logic [3:0][3:0]   m_be_i;
  logic [3:0]        m_gnt_o;
  logic [3:0]        m_r_valid_o;
  logic [35:0]       m_r_rdata_o;
  logic              m_r_opc_o;
  logic              s_req_o;
  logic [31:0]       s_add_o;
  logic              s_wen_o;
  logic [35:0]       s_wdata_o;
  logic [3:0]        s_be_o;
  logic              s_gnt_i;
  logic              s_r_valid_i;
  logic [35:0]       s_r_rdata_i;
  logic              s_r_opc_i;

  logic [2:0]        m3_req_i;
  logic [2:0][31:0]  m3_add_i;
  logic [2:0]        m3_wen_i;
  logic [2:0][35:0]  m3_wdata_i;
  logic [2:0][3:0]   m3_be_i;
  logic [2:0]        m3_gnt_o;
  logic [2:0]        m3_r_valid_o;
  logic [35:0]       m3_r_rdata_o;
  logic              m3_r_opc_o;
  logic              s3_req_o;
  logic [31:0]       s3_add_o;
  logic              s3_wen_o;
  logic [35:0]       s3_wdata_o;
  logic [3:0]        s3_be_o;
  logic              s3_gnt_i;

`ifdef TCDM_ARB_ERR_CAPTURE_EN
  logic              err_clr_i;
  logic              err_valid_o;
  logic [1:0]        err_id_o;
  logic [31:0]       err_addr_o;
  logic              err3_valid_o;
  logic [1:0]        err3_id_o;
  logic [31:0]       err3_addr_o;
`endif

  rsp_t              sb[$];
  rsp_t              exp_now;
  logic              exp_rsp_vld;
  logic [3:0]        exp_mask;
  int                checks = 0;
  int                errors = 0;

  always #5 clk_i = ~clk_i;

  tcdm_rr_arbiter #(.N_MASTERS(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .m_req_i     (m_req_i),
    .m_add_i     (m_add_i),
    .m_wen_i     (m_wen_i),
    .m_wdata_i   (m_wdata_i),
    .m_be_i      (m_be_i),
    .m_gnt_o     (m_gnt_o),
    .m_r_valid_o (m_r_valid_o),
    .m_r_rdata_o (m_r_rdata_o),
    .m_r_opc_o   (m_r_opc_o),
    .s_req_o     (s_req_o),
    .s_add_o     (s_add_o),
    .s_wen_o     (s_wen_o),
    .s_wdata_o   (s_wdata_o),
    .s_be_o      (s_be_o),
    .s_gnt_i     (s_gnt_i),
    .s_r_valid_i (s_r_valid_i),
    .s_r_rdata_i (s_r_rdata_i),
    .s_r_opc_i   (s_r_opc_i)
`ifdef TCDM_ARB_ERR_CAPTURE_EN
    ,
    .err_clr_i   (err_clr_i),
    .err_valid_o (err_valid_o),
    .err_id_o    (err_id_o),
    .err_addr_o  (err_addr_o)
`endif
  );

  tcdm_rr_arbiter #(.N_MASTERS(3)) dut3 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .m_req_i     (m3_req_i),
    .m_add_i     (m3_add_i),
    .m_wen_i     (m3_wen_i),
    .m_wdata_i   (m3_wdata_i),
    .m_be_i      (m3_be_i),
    .m_gnt_o     (m3_gnt_o),
    .m_r_valid_o (m3_r_valid_o),
    .m_r_rdata_o (m3_r_rdata_o),
    .m_r_opc_o   (m3_r_opc_o),
    .s_req_o     (s3_req_o),
    .s_add_o     (s3_add_o),
    .s_wen_o     (s3_wen_o),
    .s_wdata_o   (s3_wdata_o),
    .s_be_o      (s3_be_o),
    .s_gnt_i     (s3_gnt_i),
    .s_r_valid_i (1'b0),
    .s_r_rdata_i (36'h0),
    .s_r_opc_i   (1'b0)
`ifdef TCDM_ARB_ERR_CAPTURE_EN
    ,
    .err_clr_i   (1'b0),
    .err_valid_o (err3_valid_o),
    .err_id_o    (err3_id_o),
    .err_addr_o  (err3_addr_o)
`endif
  );

`ifndef SYNTHESIS
  // A locked master must keep its request up until the handshake.
  always @(posedge clk_i) begin
    if (!rst_i && dut.lock_vld) begin
      assert (m_req_i[dut.lock_id])
        else $error("[TB] protocol violation: locked master %0d dropped req", dut.lock_id);
    end
  end
`endif

  task automatic set_defaults();
    m_req_i     = '0;
    s_gnt_i     = 1'b0;
    s_r_valid_i = 1'b0;
    s_r_rdata_i = '0;
    s_r_opc_i   = 1'b0;
    m3_req_i    = '0;
    s3_gnt_i    = 1'b0;
`ifdef TCDM_ARB_ERR_CAPTURE_EN
    err_clr_i   = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      m_add_i[i]   = 32'h1000_0000 + 32'(i) * 32'h100;
      m_wen_i[i]   = 1'b1;
      m_wdata_i[i] = 36'hA_0000_0000 + 36'(i);
      m_be_i[i]    = 4'hF;
    end
    for (int i = 0; i < 3; i++) begin
      m3_add_i[i]   = 32'h2000_0000 + 32'(i) * 32'h40;
      m3_wen_i[i]   = 1'b1;
      m3_wdata_i[i] = '0;
      m3_be_i[i]    = 4'hF;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    set_defaults();
    sb.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Drives the slave response owed for last cycle's grant (if any).
  task automatic drive_rsp();
    if (sb.size() > 0) begin
      exp_now     = sb.pop_front();
      exp_rsp_vld = 1'b1;
      exp_mask    = 4'(1 << exp_now.id);
      s_r_valid_i = 1'b1;
      s_r_rdata_i = exp_now.data;
      s_r_opc_i   = exp_now.opc;
    end else begin
      exp_rsp_vld = 1'b0;
      exp_mask    = 4'b0000;
      s_r_valid_i = 1'b0;
      s_r_rdata_i = '0;
      s_r_opc_i   = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    set_defaults();
    @(negedge clk_i);
    #1;
    checks++;
    if (m_gnt_o !== 4'b0000 || m_r_valid_o !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_outputs gnt=%b rvalid=%b want 0000/0000", m_gnt_o, m_r_valid_o);
    end
    checks++;
    if (s_req_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_sreq_idle got %b want 0", s_req_o);
    end
    m_req_i = 4'b0010;
    #1;
    checks++;
    if (s_req_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_sreq_follows got %b want 1", s_req_o);
    end
    @(negedge clk_i);
    m_req_i = '0;
    rst_i = 1'b0;
  endtask

  task automatic test_single_read();
    apply_reset();
    @(negedge clk_i);
    m_req_i    = 4'b0100;
    m_add_i[2] = 32'h1C00_0000;
    s_gnt_i    = 1'b1;
    drive_rsp();
    #1;
    checks++;
    if (m_gnt_o !== 4'b0100 || s_add_o !== 32'h1C00_0000 || s_wen_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_grant gnt=%b add=%h wen=%b want 0100/1c000000/1",
               m_gnt_o, s_add_o, s_wen_o);
    end
    sb.push_back('{id: 2, data: 36'h9_DEAD_BEEF, opc: 1'b0});
    @(negedge clk_i);
    m_req_i = '0;
    s_gnt_i = 1'b0;
    drive_rsp();
    #1;
    checks++;
    if (m_r_valid_o !== 4'b0100 || m_r_rdata_o !== 36'h9_DEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL single_rsp rvalid=%b rdata=%h want 0100/9deadbeef",
               m_r_valid_o, m_r_rdata_o);
    end
  endtask

  task automatic test_rotation();
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_i);
      m_req_i = (k < 8) ? 4'b1111 : 4'b0000;
      s_gnt_i = (k < 8);
      drive_rsp();
      #1;
      if (exp_rsp_vld) begin
        checks++;
        if (m_r_valid_o !== exp_mask || m_r_rdata_o !== exp_now.data) begin
          errors++;
          $display("[TB] FAIL rot_rsp k=%0d rvalid=%b rdata=%h want %b/%h",
                   k, m_r_valid_o, m_r_rdata_o, exp_mask, exp_now.data);
        end
      end
      if (k < 8) begin
        checks++;
        if (m_gnt_o !== 4'(1 << (k % 4)) || s_add_o !== m_add_i[k % 4]) begin
          errors++;
          $display("[TB] FAIL rot_grant k=%0d gnt=%b add=%h want %b/%h",
                   k, m_gnt_o, s_add_o, 4'(1 << (k % 4)), m_add_i[k % 4]);
        end
        sb.push_back('{id: k % 4, data: 36'h5_0000_0000 | 36'(k), opc: 1'b0});
      end
    end
  endtask

  task automatic test_lock();
    apply_reset();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_i);
      m_req_i = (c == 1) ? 4'b0010 : (c <= 4) ? 4'b0011 : (c == 5) ? 4'b0001 : 4'b0000;
      s_gnt_i = (c >= 4);
      drive_rsp();
      #1;
      if (c <= 3) begin
        checks++;
        if (m_gnt_o !== 4'b0000 || s_add_o !== m_add_i[1] || s_req_o !== 1'b1) begin
          errors++;
          $display("[TB] FAIL lock_hold c=%0d gnt=%b add=%h req=%b want 0000/%h/1",
                   c, m_gnt_o, s_add_o, s_req_o, m_add_i[1]);
        end
      end else if (c == 4) begin
        checks++;
        if (m_gnt_o !== 4'b0010) begin
          errors++;
          $display("[TB] FAIL lock_release gnt=%b want 0010", m_gnt_o);
        end
        sb.push_back('{id: 1, data: 36'h1_1111_0001, opc: 1'b0});
      end else if (c == 5) begin
        checks++;
        if (m_gnt_o !== 4'b0001 || m_r_valid_o !== exp_mask) begin
          errors++;
          $display("[TB] FAIL lock_next gnt=%b rvalid=%b want 0001/%b",
                   m_gnt_o, m_r_valid_o, exp_mask);
        end
        sb.push_back('{id: 0, data: 36'h1_1111_0000, opc: 1'b0});
      end else begin
        checks++;
        if (m_r_valid_o !== 4'b0001 || m_r_rdata_o !== 36'h1_1111_0000) begin
          errors++;
          $display("[TB] FAIL lock_rsp rvalid=%b rdata=%h want 0001/111110000",
                   m_r_valid_o, m_r_rdata_o);
        end
      end
    end
  endtask

  task automatic test_dropped_response();
    apply_reset();
    @(negedge clk_i);
    s_r_valid_i = 1'b1;
    s_r_rdata_i = 36'h3_CAFE_F00D;
    s_r_opc_i   = 1'b1;
    #1;
    checks++;
    if (m_r_valid_o !== 4'b0000 || m_r_rdata_o !== 36'h3_CAFE_F00D || m_r_opc_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dropped_rsp rvalid=%b rdata=%h opc=%b want 0000/3cafef00d/1",
               m_r_valid_o, m_r_rdata_o, m_r_opc_o);
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    @(negedge clk_i);
    m_req_i = 4'b0010;
    s_gnt_i = 1'b1;
    #1;
    checks++;
    if (m_gnt_o !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL midrst_grant gnt=%b want 0010", m_gnt_o);
    end
    @(negedge clk_i);
    rst_i       = 1'b1;
    m_req_i     = '0;
    s_gnt_i     = 1'b0;
    s_r_valid_i = 1'b1;
    s_r_rdata_i = 36'h7_7777_7777;
    #1;
    checks++;
    if (m_r_valid_o !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midrst_rsp rvalid=%b want 0000", m_r_valid_o);
    end
    @(negedge clk_i);
    rst_i       = 1'b0;
    s_r_valid_i = 1'b0;
    m_req_i     = 4'b1111;
    s_gnt_i     = 1'b1;
    #1;
    checks++;
    if (m_gnt_o !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL midrst_ptr gnt=%b want 0001", m_gnt_o);
    end
    @(negedge clk_i);
    m_req_i = 4'b1000;
    s_gnt_i = 1'b0;
    #1;
    checks++;
    if (m_gnt_o !== 4'b0000 || s_add_o !== m_add_i[3]) begin
      errors++;
      $display("[TB] FAIL midrst_stall gnt=%b add=%h want 0000/%h", m_gnt_o, s_add_o, m_add_i[3]);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i   = 1'b0;
    m_req_i = 4'b0001;
    s_gnt_i = 1'b1;
    #1;
    checks++;
    if (m_gnt_o !== 4'b0001 || s_add_o !== m_add_i[0]) begin
      errors++;
      $display("[TB] FAIL midrst_unlock gnt=%b add=%h want 0001/%h", m_gnt_o, s_add_o, m_add_i[0]);
    end
    @(negedge clk_i);
    m_req_i = '0;
    s_gnt_i = 1'b0;
  endtask

  task automatic test_wrap3();
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk_i);
      m3_req_i = 3'b111;
      s3_gnt_i = 1'b1;
      #1;
      checks++;
      if (m3_gnt_o !== 3'(1 << (k % 3)) || s3_add_o !== m3_add_i[k % 3]) begin
        errors++;
        $display("[TB] FAIL wrap3 k=%0d gnt=%b add=%h want %b/%h",
                 k, m3_gnt_o, s3_add_o, 3'(1 << (k % 3)), m3_add_i[k % 3]);
      end
    end
    @(negedge clk_i);
    m3_req_i = '0;
    s3_gnt_i = 1'b0;
  endtask

`ifdef TCDM_ARB_ERR_CAPTURE_EN
  task automatic test_err_capture();
    apply_reset();
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk_i);
      m_add_i[3] = 32'h1A10_0000;
      m_wen_i[3] = 1'b0;
      m_add_i[0] = 32'h1C00_0010;
      m_req_i    = (c == 1 || c == 5) ? 4'b1000 : (c == 2) ? 4'b0001 : 4'b0000;
      s_gnt_i    = (c == 1 || c == 2 || c == 5);
      err_clr_i  = (c == 4 || c == 6);
      drive_rsp();
      #1;
      if (c == 1) begin
        checks++;
        if (m_gnt_o !== 4'b1000 || s_wen_o !== 1'b0 || s_add_o !== 32'h1A10_0000) begin
          errors++;
          $display("[TB] FAIL err_write_grant gnt=%b wen=%b add=%h", m_gnt_o, s_wen_o, s_add_o);
        end
      end else if (c == 2) begin
        checks++;
        if (m_r_valid_o !== 4'b1000 || m_r_opc_o !== 1'b1 || err_valid_o !== 1'b0) begin
          errors++;
          $display("[TB] FAIL err_rsp rvalid=%b opc=%b errv=%b want 1000/1/0",
                   m_r_valid_o, m_r_opc_o, err_valid_o);
        end
      end else if (c == 3 || c == 4) begin
        checks++;
        if (err_valid_o !== 1'b1 || err_id_o !== 2'd3 || err_addr_o !== 32'h1A10_0000) begin
          errors++;
          $display("[TB] FAIL err_capture c=%0d valid=%b id=%0d addr=%h want 1/3/1a100000",
                   c, err_valid_o, err_id_o, err_addr_o);
        end
      end else if (c == 5 || c == 7) begin
        checks++;
        if (err_valid_o !== 1'b0) begin
          errors++;
          $display("[TB] FAIL err_clear c=%0d valid=%b want 0", c, err_valid_o);
        end
      end
      if (s_gnt_i) begin
        sb.push_back('{id: (c == 2) ? 0 : 3, data: 36'hE_0000_0000 | 36'(c), opc: 1'b1});
      end
    end
  endtask
`endif

  initial begin
    $display("[TB] tcdm_rr_arbiter bench start");
    test_reset();
    test_single_read();
    test_rotation();
    test_lock();
    test_dropped_response();
    test_reset_midflight();
    test_wrap3();
`ifdef TCDM_ARB_ERR_CAPTURE_EN
    test_err_capture();
`endif
    @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
